// File: rtl/cdc_pkg.sv
// ============================================================================
// Module  : cdc_pkg
// Brief   : Shared types and constants for the pclk-to-sclk req/ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cdc_pkg;

  localparam int c_DATA_W_DEFAULT  = 6;
  localparam int c_SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cdc_sync_bit.sv
// ============================================================================
// Module  : cdc_sync_bit
// Brief   : Multi-flop single-bit synchronizer; also used on the pclk ack path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability protection, so clamp up.
  localparam int c_N = (STAGES < c_SYNC_STAGES_MIN) ? c_SYNC_STAGES_MIN : STAGES;

  logic [c_N-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[c_N-2:0], d};
    end
  end

  assign q = r_sync[c_N-1];

endmodule

`default_nettype wire

// File: rtl/cdc_hs_rx.sv
// ============================================================================
// Module  : cdc_hs_rx
// Brief   : sclk-side receiver of the four-phase req/ack handshake with
//           valid/ready output buffer, sequence check and transfer counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = c_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int SEQ_CHECK   = 1
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rx_count,
  output logic              seq_err,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] c_DATA_ONE = DATA_W'(1);

  logic              w_req_sync;
  logic              w_buf_free;
  logic              w_capture;
  state_t            r_state;
  logic              r_ack;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_rx_count;
  logic              r_proto_err;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (sclk),
    .rst_n (rst_n),
    .d     (req_async),
    .q     (w_req_sync)
  );

  // A held request in ACK must never re-capture; only IDLE/STALL may load.
  assign w_buf_free = !r_out_valid || out_ready;
  assign w_capture  = (r_state != ACK) && w_req_sync && w_buf_free;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rx_count  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_sync) begin
            r_state <= w_buf_free ? ACK : STALL;
          end
        end
        STALL: begin
          if (!w_req_sync) begin
            r_state     <= IDLE;
            r_proto_err <= 1'b1;
          end else if (w_buf_free) begin
            r_state <= ACK;
          end
        end
        ACK: begin
          if (!w_req_sync) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase

      // Capture and consume may coincide: the new word simply replaces the old.
      if (w_capture) begin
        r_ack       <= 1'b1;
        r_out_data  <= data_async;
        r_out_valid <= 1'b1;
        r_rx_count  <= r_rx_count + c_CNT_ONE;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  generate
    if (SEQ_CHECK != 0) begin : g_seq_on
      logic [DATA_W-1:0] r_last;
      logic              r_ref_vld;
      logic              r_seq_err;

      always_ff @(posedge sclk) begin
        if (!rst_n) begin
          r_last    <= '0;
          r_ref_vld <= 1'b0;
          r_seq_err <= 1'b0;
        end else if (w_capture) begin
          if (r_ref_vld && (data_async != r_last + c_DATA_ONE)) begin
            r_seq_err <= 1'b1;
          end
          r_last    <= data_async;
          r_ref_vld <= 1'b1;
        end
      end

      assign seq_err = r_seq_err;
    end else begin : g_seq_off
      assign seq_err = 1'b0;
    end
  endgenerate

  assign ack       = r_ack;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign rx_count  = r_rx_count;
  assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_cdc_hs_rx.sv
// ============================================================================
// Module  : tb_cdc_hs_rx
// Brief   : Self-checking bench for cdc_hs_rx (vector table, directed corner
//           cases and randomized handshakes against a word-level model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_hs_rx;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_async = 1'b0;
  logic [5:0]  data_async = '0;
  logic        ack;
  logic [5:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] rx_count;
  logic        seq_err;
  logic        proto_err;

  cdc_hs_rx #(
    .DATA_W      (6),
    .SYNC_STAGES (2),
    .CNT_W       (16),
    .SEQ_CHECK   (1)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rx_count   (rx_count),
    .seq_err    (seq_err),
    .proto_err  (proto_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic        req;
    logic [5:0]  data;
    logic        rdy;
    logic        e_ack;
    logic        e_vld;
    logic [5:0]  e_dout;
    logic [15:0] e_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Word-level model: every word offered is eventually delivered, in order.
  logic [5:0]  exp_q[$];
  logic [15:0] exp_cnt;
  logic        exp_seq;
  logic        have_prev;
  logic [5:0]  prev;
  logic        rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_cnt   = '0;
    exp_seq   = 1'b0;
    have_prev = 1'b0;
    prev      = '0;
  endtask

  task automatic model_send(input logic [5:0] d);
    exp_q.push_back(d);
    if (have_prev && (d != 6'((int'(prev) + 1) % 64))) exp_seq = 1'b1;
    prev      = d;
    have_prev = 1'b1;
    exp_cnt   = exp_cnt + 16'd1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_async = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(rx_count), 32'd0);
    check("rst_errs", {30'd0, seq_err, proto_err}, 32'd0);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (ack !== lvl && n < 200) begin
      step();
      n++;
    end
    if (ack !== lvl) begin
      errors++;
      checks++;
      $display("FAIL ack_timeout: ack=%0b expected %0b at %0t", ack, lvl, $time);
    end
  endtask

  task automatic send_word(input logic [5:0] d);
    model_send(d);
    data_async = d;
    req_async  = 1'b1;
    wait_ack(1'b1);
    req_async  = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("count", 32'(rx_count), 32'(exp_cnt));
    check("seq_err", 32'(seq_err), 32'(exp_seq));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int   n;
    logic [5:0] d;

    tbl[0]  = '{1'b1, 6'h05, 1'b1, 1'b0, 1'b0, 6'h00, 16'd0};
    tbl[1]  = '{1'b1, 6'h05, 1'b1, 1'b0, 1'b0, 6'h00, 16'd0};
    tbl[2]  = '{1'b1, 6'h05, 1'b1, 1'b1, 1'b1, 6'h05, 16'd1};
    tbl[3]  = '{1'b1, 6'h05, 1'b1, 1'b1, 1'b0, 6'h05, 16'd1};
    tbl[4]  = '{1'b0, 6'h05, 1'b1, 1'b1, 1'b0, 6'h05, 16'd1};
    tbl[5]  = '{1'b0, 6'h05, 1'b1, 1'b1, 1'b0, 6'h05, 16'd1};
    tbl[6]  = '{1'b0, 6'h05, 1'b1, 1'b0, 1'b0, 6'h05, 16'd1};
    tbl[7]  = '{1'b0, 6'h05, 1'b0, 1'b0, 1'b0, 6'h05, 16'd1};
    tbl[8]  = '{1'b1, 6'h06, 1'b0, 1'b0, 1'b0, 6'h05, 16'd1};
    tbl[9]  = '{1'b1, 6'h06, 1'b0, 1'b0, 1'b0, 6'h05, 16'd1};
    tbl[10] = '{1'b1, 6'h06, 1'b0, 1'b1, 1'b1, 6'h06, 16'd2};
    tbl[11] = '{1'b1, 6'h06, 1'b0, 1'b1, 1'b1, 6'h06, 16'd2};
    tbl[12] = '{1'b0, 6'h06, 1'b0, 1'b1, 1'b1, 6'h06, 16'd2};
    tbl[13] = '{1'b0, 6'h06, 1'b0, 1'b1, 1'b1, 6'h06, 16'd2};
    tbl[14] = '{1'b0, 6'h06, 1'b0, 1'b0, 1'b1, 6'h06, 16'd2};
    tbl[15] = '{1'b0, 6'h06, 1'b1, 1'b0, 1'b0, 6'h06, 16'd2};

    model_clear();
    rand_done = 1'b0;

    // Output monitor: each valid&&ready handshake must deliver the next model word.
    fork
      forever begin
        @(negedge sclk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_word: got %0h with empty model queue", out_data);
          end else begin
            check("out_word", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    do_reset();

    // Cycle-accurate vectors: single word with ready high, then a held word.
    model_send(6'h05);
    model_send(6'h06);
    for (int i = 0; i < 16; i++) begin
      req_async  = tbl[i].req;
      data_async = tbl[i].data;
      out_ready  = tbl[i].rdy;
      step();
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      check($sformatf("vec%0d_vld", i), 32'(out_valid), 32'(tbl[i].e_vld));
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].e_dout));
      check($sformatf("vec%0d_cnt", i), 32'(rx_count), 32'(tbl[i].e_cnt));
    end
    drain();

    // 70 incrementing words across the 3F->00 wrap.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 70; i++) send_word(6'((62 + i) % 64));
    drain();
    check("wrap_count70", 32'(rx_count), 32'd70);
    check("wrap_seq_ok", 32'(seq_err), 32'd0);

    // Backpressure: second request stalls until one ready cycle.
    do_reset();
    send_word(6'h06);
    model_send(6'h07);
    data_async = 6'h07;
    req_async  = 1'b1;
    repeat (6) step();
    check("stall_ack", 32'(ack), 32'd0);
    check("stall_vld", 32'(out_valid), 32'd1);
    check("stall_data", 32'(out_data), 32'h06);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("unstall_ack", 32'(ack), 32'd1);
    check("unstall_vld", 32'(out_valid), 32'd1);
    check("unstall_data", 32'(out_data), 32'h07);
    check("unstall_cnt", 32'(rx_count), 32'd2);
    req_async = 1'b0;
    wait_ack(1'b0);
    drain();

    // Sequence error is sticky through later correct words.
    do_reset();
    out_ready = 1'b1;
    send_word(6'h01);
    send_word(6'h02);
    check("seq_before", 32'(seq_err), 32'd0);
    send_word(6'h04);
    check("seq_set", 32'(seq_err), 32'd1);
    send_word(6'h05);
    send_word(6'h06);
    check("seq_sticky", 32'(seq_err), 32'(exp_seq));
    drain();

    // Request dropped while stalled: protocol error, no capture.
    do_reset();
    send_word(6'h10);
    data_async = 6'h11;
    req_async  = 1'b1;
    repeat (5) step();
    check("perr_ack_held", 32'(ack), 32'd0);
    req_async = 1'b0;
    repeat (4) step();
    check("perr_flag", 32'(proto_err), 32'd1);
    check("perr_cnt", 32'(rx_count), 32'd1);
    check("perr_data", 32'(out_data), 32'h10);
    check("perr_ack", 32'(ack), 32'd0);
    drain();
    check("perr_sticky", 32'(proto_err), 32'd1);

    // Reset while in ACK with the request still held.
    do_reset();
    model_send(6'h20);
    data_async = 6'h20;
    req_async  = 1'b1;
    wait_ack(1'b1);
    rst_n = 1'b0;
    step();
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_vld", 32'(out_valid), 32'd0);
    check("midrst_cnt", 32'(rx_count), 32'd0);
    model_clear();
    rst_n = 1'b1;
    model_send(6'h20);
    n = 0;
    while (ack !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("midrst_recapture_edges", 32'(n), 32'd3);
    check("midrst_recapture_cnt", 32'(rx_count), 32'd1);
    check("midrst_recapture_data", 32'(out_data), 32'h20);
    req_async = 1'b0;
    wait_ack(1'b0);
    drain();

    // Randomized traffic with random backpressure and occasional sequence jumps.
    do_reset();
    fork
      while (!rand_done) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    join_none
    d = 6'($urandom_range(0, 63));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) d = 6'($urandom_range(0, 63));
      send_word(d);
      check("rand_seq", 32'(seq_err), 32'(exp_seq));
      check("rand_cnt", 32'(rx_count), 32'(exp_cnt));
      d = d + 6'd1;
    end
    rand_done = 1'b1;
    repeat (3) step();
    drain();
    check("rand_perr", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdc_hs_rx.md
# cdc_hs_rx

Receiving endpoint of the four-phase req/ack handshake used for pclk-to-sclk transfers. The block runs entirely in the sclk domain, synchronizes the pclk-domain request, captures the quasi-static data bus, returns an acknowledge, and presents each captured word on a valid/ready output. It also checks that words arrive as an incrementing sequence and counts completed transfers.

## Interface
Parameters:
- DATA_W, 6: width of the transferred word.
- SYNC_STAGES, 2: flops in the req synchronizer, minimum 2.
- CNT_W, 16: width of the transfer counter.
- SEQ_CHECK, 1: 1 enables the sequence check; 0 ties seq_err to 0.

Ports:
- sclk  in  1  receive-domain clock.
- rst_n  in  1  reset, synchronous, active-low; clock sclk.
- req_async  in  1  request from the pclk domain, asynchronous to sclk.
- data_async  in  DATA_W  data from the pclk domain; the sender holds it stable while req_async is 1.
- ack  out  1  acknowledge to the pclk domain, driven straight from a flop.
- out_data  out  DATA_W  captured word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word; a transfer completes when out_valid and out_ready are both 1.
- rx_count  out  CNT_W  number of completed captures, modulo 2^CNT_W.
- seq_err  out  1  sticky: a captured word was not the previous word + 1.
- proto_err  out  1  sticky: req dropped before ack was returned.

## Operation
- req_sync is the output of the last stage of the synchronizer on req_async. Only req_sync is used. data_async is sampled only on the capture edge.
- buf_free = !out_valid || out_ready.
- FSM states: IDLE, STALL, ACK.
  - IDLE, ack=0. If req_sync && buf_free: capture, then go to ACK. If req_sync && !buf_free: go to STALL.
  - STALL, ack=0. If req_sync && buf_free: capture, then go to ACK. If !req_sync: set proto_err, go to IDLE, no capture.
  - ACK, ack=1. If !req_sync: set ack=0 and go to IDLE. Otherwise stay in ACK; a held req never causes a second capture.
- Capture, in a single edge:
  - out_data <= data_async, out_valid <= 1, ack <= 1.
  - rx_count <= rx_count + 1, wrapping from all-ones to 0.
- Sequence check:
  - The first capture after reset only loads the reference value.
  - Every later capture sets seq_err if data_async != (last + 1) mod 2^DATA_W. All-ones followed by 0 is legal.
- Output buffer:
  - out_valid clears on an edge where out_ready=1 and there is no capture.
  - If a capture and out_ready=1 fall on the same edge, the old word is consumed, the new word is loaded, and out_valid stays 1.
- seq_err and proto_err clear only on reset.

## Timing
- Reset values:
  - ack=0, out_valid=0, out_data=0, rx_count=0, seq_err=0, proto_err=0.
  - Synchronizer flops all 0, FSM in IDLE, reference-valid flag cleared.
- Capture latency: with edge 1 being the first sclk edge that samples req_async=1, req_sync is 1 after edge SYNC_STAGES. Capture, ack=1 and out_valid=1 all take effect on edge SYNC_STAGES+1 (edge 3 at the default) when the buffer is free.
- Release latency: ack falls on edge SYNC_STAGES+1 counted from the first edge that samples req_async=0.
- Backpressure: ack is withheld while the buffer is full, so the sender is stalled with no data loss and no overflow.
- Full round trip from sclk's view: at least 2*(SYNC_STAGES+1) sclk cycles per word, plus the pclk-side synchronizer delay.
- Reset mid-transfer: ack drops at the reset edge and any buffered word is discarded. If the sender still holds req high after reset, that request is seen as new and captured again; rx_count counts it as transfer 1.

## Structure
- Shared package cdc_pkg holds:
  - the state enum (IDLE, STALL, ACK) with 2-bit encoding;
  - the default DATA_W = 6;
  - the SYNC_STAGES minimum constant.
- Sub-module cdc_sync_bit (parameter STAGES) provides the req synchronizer. The pclk-side sender reuses it for its ack path.
- There is no combinational path from req_async or data_async to any output.

## Test plan
- Single word, out_ready=1, sender drives 6'h05 and raises req → ack and out_valid rise on the 3rd sclk edge with out_data=6'h05; req falls → ack falls 3 edges later; rx_count=1.
- 70 words incrementing from 6'h3E, out_ready=1 → values 3E, 3F, 00, 01, … captured in order; seq_err stays 0; rx_count=70.
- out_ready=0 with one word already buffered, new req with 6'h07 → FSM holds in STALL, ack stays 0; out_ready=1 for one cycle → 6'h07 loads on that same edge, out_valid stays 1, ack rises.
- Sequence 6'h01, 6'h02, 6'h04 → seq_err asserts on the third capture and stays set through later correct words until reset.
- Protocol errors:
  - req raised while the buffer is full, then dropped before ack → proto_err=1, no capture, rx_count unchanged.
  - Reset pulsed while in ACK → ack=0 and out_valid=0 on the reset edge; with req still high, the word is captured again ≥3 edges after reset is released.
